multi_button_pulser: RTL and testbench

Parametrised N-channel front end for push-buttons and switches. Per channel it provides:
- a 2-FF synchroniser;
- a counter-based debouncer;
- a one-cycle press pulse and a one-cycle release pulse;
- the debounced level.

It sits between board button pins and controller FSMs, and replaces slow-clock debouncing with a count of system-clock cycles.

---
 rtl/multi_button_pulser.sv | 60 ++++++
 tb/tb_multi_button_pulser.sv | 108 ++++++++++
 2 files changed

// File: rtl/multi_button_pulser.sv
// multi_button_pulser: per-channel 2-FF sync, counter debounce, press/release pulses and debounced level.
// Define AUTO_REPEAT_EN to add held-button repeat pulses on oSP.
module multi_button_pulser #(
  parameter int N          = 5,
  parameter int DB_CNT     = 16,
  parameter int DB_W       = 5,
  parameter int RPT_DELAY  = 1000,
  parameter int RPT_PERIOD = 250
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic [N-1:0] iX,
  output logic [N-1:0] oSP,
  output logic [N-1:0] oRel,
  output logic [N-1:0] oB,
  output logic         oAny
);
`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = RPT_DELAY > RPT_PERIOD ? RPT_DELAY : RPT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX);
`endif
  for (genvar i = 0; i < N; i++) begin : g_ch
    logic            s1_q, s2_q, b_q, sp_q, rel_q;
    logic            acc, rise, fall, rpt;
    logic [DB_W-1:0] c_q, c_d;
    assign acc  = s2_q != b_q && c_q == DB_W'(DB_CNT - 1);
    assign rise = acc && s2_q;
    assign fall = acc && !s2_q;
    assign c_d  = (s2_q == b_q || acc) ? '0 : c_q + 1'b1;
    always_ff @(posedge iClk) begin
      if (iRst) begin
        {s1_q, s2_q, b_q, sp_q, rel_q} <= '0;
        c_q <= '0;
      end else begin
        s1_q  <= iX[i];
        s2_q  <= s1_q;
        c_q   <= c_d;
        b_q   <= acc ? s2_q : b_q;
        sp_q  <= rise || rpt;
        rel_q <= fall;
      end
    end
`ifdef AUTO_REPEAT_EN
    // r_q counts cycles since the last press/repeat pulse; rep_q selects delay vs period
    logic [RW-1:0] r_q;
    logic          rep_q;
    assign rpt = b_q && !fall && r_q == (rep_q ? RW'(RPT_PERIOD - 1) : RW'(RPT_DELAY - 1));
    always_ff @(posedge iClk) begin
      r_q   <= (iRst || !b_q || fall || rpt) ? '0 : r_q + 1'b1;
      rep_q <= (iRst || !b_q || fall) ? 1'b0 : (rpt ? 1'b1 : rep_q);
    end
`else
    assign rpt = 1'b0;
`endif
    assign oSP[i]  = sp_q;
    assign oRel[i] = rel_q;
    assign oB[i]   = b_q;
  end
  assign oAny = |oB;
endmodule

// File: tb/tb_multi_button_pulser.sv
// tb_multi_button_pulser: table-driven per-cycle vectors checked through a scoreboard queue.
module tb_multi_button_pulser;
  localparam int N = 5;
`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  typedef struct {
    string          tag;
    logic           rst;
    logic [N-1:0]   x;
    logic [N-1:0]   sp;
    logic [N-1:0]   rel;
    logic [N-1:0]   b;
  } vec_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] x   = '0;
  logic [N-1:0] sp, rel, b;
  logic         any;
  vec_t         vt[$];
  vec_t         sb[$];
  int           nvec = 0;
  int           nerr = 0;
  multi_button_pulser #(
    .N(N), .DB_CNT(4), .DB_W(3), .RPT_DELAY(10), .RPT_PERIOD(4)
  ) dut (
    .iClk(clk), .iRst(rst), .iX(x), .oSP(sp), .oRel(rel), .oB(b), .oAny(any)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input string t, input logic r, input logic [N-1:0] xx,
                              input logic [N-1:0] sp_e, input logic [N-1:0] rel_e,
                              input logic [N-1:0] b_e);
    vec_t v;
    v.tag = t; v.rst = r; v.x = xx; v.sp = sp_e; v.rel = rel_e; v.b = b_e;
    return v;
  endfunction
  task automatic add(input vec_t v, input int n);
    for (int k = 0; k < n; k++) vt.push_back(v);
  endtask
  task automatic check();
    vec_t e;
    e = sb.pop_front();
    nvec++;
    if (sp !== e.sp || rel !== e.rel || b !== e.b || any !== |e.b) begin
      nerr++;
      $display("FAIL %s @%0t: got sp=%b rel=%b b=%b any=%b, want sp=%b rel=%b b=%b any=%b",
               e.tag, $time, sp, rel, b, any, e.sp, e.rel, e.b, |e.b);
    end
  endtask
  task automatic step(input vec_t v);
    @(negedge clk);
    rst = v.rst;
    x   = v.x;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check();
  endtask
  initial begin
    // reset state
    add(mk("reset", 1, 5'b00000, 0, 0, 0), 2);
    // single press on ch0, latency DB_CNT+2 edges
    add(mk("t1_wait",  0, 5'b00001, 5'b00000, 0, 5'b00000), 5);
    add(mk("t1_press", 0, 5'b00001, 5'b00001, 0, 5'b00001), 1);
    add(mk("t1_held",  0, 5'b00001, 5'b00000, 0, 5'b00001), 1);
    // 3-cycle bounce on ch1 is rejected
    add(mk("t2_bounce", 0, 5'b00011, 0, 0, 5'b00001), 3);
    add(mk("t2_after",  0, 5'b00001, 0, 0, 5'b00001), 4);
    // release ch0; with repeat the first repeat lands in here, the second collides with release
    add(mk("t3_wait", 0, 5'b00000, 0, 0, 5'b00001), 1);
    add(mk("t3_rpt",  0, 5'b00000, AR ? 5'b00001 : 5'b00000, 0, 5'b00001), 1);
    add(mk("t3_wait", 0, 5'b00000, 0, 0, 5'b00001), 3);
    add(mk("t3_rel",  0, 5'b00000, 0, 5'b00001, 5'b00000), 1);
    add(mk("t3_idle", 0, 5'b00000, 0, 0, 5'b00000), 1);
    // simultaneous press/release on three channels
    add(mk("t4_wait",  0, 5'b10110, 0, 0, 0), 5);
    add(mk("t4_press", 0, 5'b10110, 5'b10110, 0, 5'b10110), 1);
    add(mk("t4_held",  0, 5'b10110, 0, 0, 5'b10110), 1);
    add(mk("t4_wait",  0, 5'b00000, 0, 0, 5'b10110), 5);
    add(mk("t4_rel",   0, 5'b00000, 0, 5'b10110, 0), 1);
    add(mk("t4_idle",  0, 5'b00000, 0, 0, 0), 1);
    foreach (vt[k]) step(vt[k]);
    // reset mid-debounce on ch2, button held across reset release
    for (int j = 0; j < 4; j++) step(mk("t5_pre", 0, 5'b00100, 0, 0, 0));
    for (int j = 0; j < 2; j++) step(mk("t5_rst", 1, 5'b00100, 0, 0, 0));
    for (int j = 1; j <= 8; j++)
      step(mk("t5_post", 0, 5'b00100, j == 6 ? 5'b00100 : 5'b0, 0, j >= 6 ? 5'b00100 : 5'b0));
    for (int j = 1; j <= 7; j++)
      step(mk("t5_rel", 0, 5'b00000, 0, j == 6 ? 5'b00100 : 5'b0, j < 6 ? 5'b00100 : 5'b0));
    // long hold on ch3: repeats at P+10, P+14, P+18 only when enabled; release kills P+22
    for (int i = 1; i <= 36; i++) begin
      logic rep_hit;
      rep_hit = AR && (i == 16 || i == 20 || i == 24);
      step(mk("t6_hold", 0, i < 23 ? 5'b01000 : 5'b00000,
              (i == 6 || rep_hit) ? 5'b01000 : 5'b0,
              i == 28 ? 5'b01000 : 5'b0,
              (i >= 6 && i < 28) ? 5'b01000 : 5'b0));
    end
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
